// File: rtl/if_stage_pkg.sv
// Shared constants, state encodings and helpers for the instruction-fetch stage.
package if_stage_pkg;

    localparam logic [31:0] NOP              = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_HOLD = 2'd3;

    typedef enum logic [1:0] {
        StIdle = ST_IDLE,
        StReq  = ST_REQ,
        StWait = ST_WAIT,
        StHold = ST_HOLD
    } fetch_state_e;

    function automatic logic [31:0] pc_inc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/if_stage_if.sv
// Instruction-memory fetch handshake: single outstanding request, separate response.
interface if_stage_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rvalid,
        output imem_rdata
    );

endinterface

// File: rtl/if_stage_if_id_reg.sv
// IF/ID pipeline register: hold beats load, load beats bubble.
module if_id_reg
    import if_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        bubble,
    input  logic        hold,
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    input  logic [31:0] pc_plus4,
    output logic [31:0] instr_id,
    output logic [31:0] pc_id,
    output logic [31:0] pc_plus4_id,
    output logic        valid_id
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_id    <= NOP;
            pc_id       <= 32'h0;
            pc_plus4_id <= 32'h0;
            valid_id    <= 1'b0;
        end else if (!hold) begin
            if (load) begin
                instr_id    <= instr;
                pc_id       <= pc;
                pc_plus4_id <= pc_plus4;
                valid_id    <= 1'b1;
            end else if (bubble) begin
                // Bubble keeps the PC fields so decode still sees a sane address.
                instr_id <= NOP;
                valid_id <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, single-outstanding imem handshake, hold buffer, IF/ID.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall_if,
    input  logic              pc_src,
    input  logic [31:0]       new_pc,
    if_stage_if.master        imem,
    output logic [31:0]       instr_id,
    output logic [31:0]       pc_id,
    output logic [31:0]       pc_plus4_id,
    output logic              valid_id
);

    fetch_state_e state_q, state_d;
    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic [31:0]  req_pc_q, req_pc_d;
    logic         drop_q, drop_d;
    logic [31:0]  hold_instr_q, hold_instr_d;
    logic [31:0]  hold_pc_q, hold_pc_d;

    logic         redirect;
    logic         fetch_req;
    logic [31:0]  fetch_addr;
    logic         deliver;
    logic [31:0]  del_instr;
    logic [31:0]  del_pc;

    assign redirect = pc_src & ~stall_if;

    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        req_pc_d     = req_pc_q;
        drop_d       = drop_q;
        hold_instr_d = hold_instr_q;
        hold_pc_d    = hold_pc_q;
        fetch_req    = 1'b0;
        fetch_addr   = fetch_pc_q;
        deliver      = 1'b0;
        del_instr    = hold_instr_q;
        del_pc       = hold_pc_q;

        if (redirect) begin
            fetch_pc_d = new_pc;
        end

        unique case (state_q)
            StIdle: state_d = StReq;
            StReq: begin
                fetch_req  = 1'b1;
                fetch_addr = redirect ? new_pc : fetch_pc_q;
                if (imem.imem_ready) begin
                    req_pc_d = fetch_addr;
                    state_d  = StWait;
                end
            end
            StWait: begin
                if (imem.imem_rvalid) begin
                    if (redirect || drop_q || !stall_if) begin
                        drop_d    = 1'b0;
                        fetch_req = 1'b1;
                        if (redirect) begin
                            fetch_addr = new_pc;
                        end else if (!drop_q) begin
                            deliver    = 1'b1;
                            del_instr  = imem.imem_rdata;
                            del_pc     = req_pc_q;
                            fetch_addr = pc_inc(req_pc_q);
                            fetch_pc_d = fetch_addr;
                        end
                        // Back-to-back issue: stay in WAIT if memory takes it now.
                        if (imem.imem_ready) begin
                            req_pc_d = fetch_addr;
                        end else begin
                            state_d = StReq;
                        end
                    end else begin
                        hold_instr_d = imem.imem_rdata;
                        hold_pc_d    = req_pc_q;
                        state_d      = StHold;
                    end
                end else if (redirect) begin
                    drop_d = 1'b1;
                end
            end
            StHold: begin
                if (redirect) begin
                    state_d = StReq;
                end else if (!stall_if) begin
                    deliver    = 1'b1;
                    fetch_pc_d = pc_inc(hold_pc_q);
                    state_d    = StReq;
                end
            end
            default: state_d = StIdle;
        endcase

        imem.imem_req  = fetch_req;
        imem.imem_addr = fetch_addr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            fetch_pc_q   <= RESET_PC;
            req_pc_q     <= 32'h0;
            drop_q       <= 1'b0;
            hold_instr_q <= 32'h0;
            hold_pc_q    <= 32'h0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            req_pc_q     <= req_pc_d;
            drop_q       <= drop_d;
            hold_instr_q <= hold_instr_d;
            hold_pc_q    <= hold_pc_d;
        end
    end

    if_id_reg u_if_id_reg (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (deliver),
        .bubble      (~stall_if & ~deliver),
        .hold        (stall_if),
        .instr       (del_instr),
        .pc          (del_pc),
        .pc_plus4    (pc_inc(del_pc)),
        .instr_id    (instr_id),
        .pc_id       (pc_id),
        .pc_plus4_id (pc_plus4_id),
        .valid_id    (valid_id)
    );

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios, then random stall/redirect/memory timing
// checked against a program-order model of the fetched instruction stream.
module tb_if_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam logic [31:0] NOP_I  = 32'h0000_0013;
    localparam logic [31:0] KEY    = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        stall_if = 1'b0;
    logic        pc_src = 1'b0;
    logic [31:0] new_pc = 32'h0;
    logic [31:0] instr_id, pc_id, pc_plus4_id;
    logic        valid_id;

    if_stage_if imem ();

    if_stage #(
        .RESET_PC(RST_PC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall_if    (stall_if),
        .pc_src      (pc_src),
        .new_pc      (new_pc),
        .imem        (imem),
        .instr_id    (instr_id),
        .pc_id       (pc_id),
        .pc_plus4_id (pc_plus4_id),
        .valid_id    (valid_id)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          lat = 1;
    bit          force_ready = 1'b1;
    bit          pend = 1'b0;
    logic [31:0] pend_addr = 32'h0;
    int          cnt = 0;
    logic [31:0] exp_next = RST_PC;
    int          n_deliv = 0;
    bit          last_acc;
    bit          last_req;
    logic [31:0] last_acc_addr = 32'h0;
    logic [31:0] last_req_addr;
    logic [31:0] p_instr, p_pc, p_pc4;
    logic        p_valid;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    // Memory: answers addr^KEY, 'lat' cycles after acceptance, one cycle of rvalid.
    task automatic mem_drive();
        imem.imem_rvalid = 1'b0;
        imem.imem_rdata  = $urandom;
        imem.imem_ready  = force_ready ? 1'b1 : ($urandom_range(9) < 7);
        if (pend && cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
                imem.imem_rvalid = 1'b1;
                imem.imem_rdata  = pend_addr ^ KEY;
            end
        end
    endtask

    task automatic cycle();
        bit          acc, rv, st, rd;
        logic [31:0] np;
        mem_drive();
        @(negedge clk);
        acc           = imem.imem_req & imem.imem_ready;
        last_req      = imem.imem_req;
        last_req_addr = imem.imem_addr;
        rv            = imem.imem_rvalid;
        st            = stall_if;
        rd            = pc_src & ~stall_if;
        np            = new_pc;
        p_instr = instr_id; p_pc = pc_id; p_pc4 = pc_plus4_id; p_valid = valid_id;
        @(posedge clk);
        #1;
        last_acc = acc;
        if (acc) last_acc_addr = last_req_addr;
        if (rv) pend = 1'b0;
        if (acc) begin
            chk("one_outstanding", pend, 0);
            pend = 1'b1; pend_addr = last_req_addr; cnt = lat;
        end
        // Reference: IF/ID shows the program-order stream, restarting at each taken redirect.
        if (st) begin
            chk("stall_hold", {instr_id, pc_id, pc_plus4_id, valid_id},
                {p_instr, p_pc, p_pc4, p_valid});
        end else if (rd) begin
            chk("redirect_bubble", {instr_id, pc_id, pc_plus4_id, valid_id},
                {NOP_I, p_pc, p_pc4, 1'b0});
            exp_next = np;
        end else if (valid_id) begin
            chk("deliver", {instr_id, pc_id, pc_plus4_id},
                {exp_next ^ KEY, exp_next, exp_next + 32'd4});
            exp_next = exp_next + 32'd4;
            n_deliv++;
        end else begin
            chk("bubble", {instr_id, pc_id, pc_plus4_id, valid_id},
                {NOP_I, p_pc, p_pc4, 1'b0});
        end
    endtask

    task automatic assert_reset();
        rst_n = 1'b0; stall_if = 1'b0; pc_src = 1'b0;
        pend = 1'b0; cnt = 0;
        imem.imem_rvalid = 1'b0; imem.imem_ready = 1'b0; imem.imem_rdata = 32'h0;
        #1;
        chk("rst_req", imem.imem_req, 0);
        chk("rst_ifid", {instr_id, pc_id, pc_plus4_id, valid_id}, {NOP_I, 32'h0, 32'h0, 1'b0});
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_next = RST_PC;
    endtask

    initial begin
        #2;
        assert_reset();

        // Reset release and zero-wait streaming
        force_ready = 1'b1; lat = 1;
        cycle(); chk("first_cycle_no_req", last_req, 0);
        cycle(); chk("first_req", {last_acc, last_acc_addr}, {1'b1, 32'h100});
        cycle(); chk("acc_104", {last_acc, last_acc_addr}, {1'b1, 32'h104});
        chk("ifid_first", {valid_id, pc_id, instr_id}, {1'b1, 32'h100, 32'hA5A5_0100});
        cycle(); chk("acc_108", {last_acc, last_acc_addr}, {1'b1, 32'h108});

        // Stall while the 0x108 response arrives
        stall_if = 1'b1;
        cycle();
        cycle(); chk("hold_no_req", last_req, 0);
        chk("hold_pc", pc_id, 32'h104);
        stall_if = 1'b0;
        cycle(); chk("hold_release", {valid_id, pc_id}, {1'b1, 32'h108});
        lat = 3;
        cycle(); chk("acc_10c", {last_acc, last_acc_addr}, {1'b1, 32'h10C});

        // Redirect while waiting on a slow response
        pc_src = 1'b1; new_pc = 32'h200;
        cycle(); chk("wait_redirect_bubble", {valid_id, instr_id}, {1'b0, NOP_I});
        pc_src = 1'b0;
        cycle(); chk("no_acc_while_drop", last_acc, 0);
        lat = 1;
        cycle(); chk("acc_200", {last_acc, last_acc_addr}, {1'b1, 32'h200});
        cycle(); chk("ifid_200", {valid_id, pc_id}, {1'b1, 32'h200});

        // Redirect in the same cycle as a response
        pc_src = 1'b1; new_pc = 32'h300;
        cycle(); chk("simul_addr", {last_req, last_req_addr}, {1'b1, 32'h300});
        pc_src = 1'b0;
        cycle(); chk("ifid_300", {valid_id, pc_id}, {1'b1, 32'h300});

        // Redirect requested during a stall is ignored
        stall_if = 1'b1; pc_src = 1'b1; new_pc = 32'h500;
        repeat (3) cycle();
        stall_if = 1'b0; pc_src = 1'b0;
        cycle(); chk("stall_redirect_ignored", {valid_id, pc_id}, {1'b1, 32'h304});

        // Wrap-around at the top of the address space
        pc_src = 1'b1; new_pc = 32'hFFFF_FFFC;
        cycle(); chk("acc_fffffffc", {last_acc, last_acc_addr}, {1'b1, 32'hFFFF_FFFC});
        pc_src = 1'b0;
        cycle(); chk("acc_wrap", {last_acc, last_acc_addr}, {1'b1, 32'h0});
        chk("ifid_wrap", {pc_id, pc_plus4_id}, {32'hFFFF_FFFC, 32'h0});

        // Reset while a request is outstanding
        lat = 3;
        cycle();
        assert_reset();
        lat = 1;
        cycle();
        cycle(); chk("restart_req", {last_acc, last_acc_addr}, {1'b1, RST_PC});

        // Random stall, redirect and memory timing
        force_ready = 1'b0;
        n_deliv = 0;
        for (int i = 0; i < 3000; i++) begin
            stall_if = ($urandom_range(3) == 0);
            pc_src   = ($urandom_range(15) == 0);
            new_pc   = $urandom & 32'hFFFF_FFFC;
            lat      = $urandom_range(4, 1);
            cycle();
        end
        stall_if = 1'b0; pc_src = 1'b0;
        chk("progress", (n_deliv > 200), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
